// File: rtl/key_event_ctrl.sv
// Key event sequencer: per-key hold timers turn press/release pulses into
// SHORT/LONG/REPEAT events, merged round-robin into a 4-entry event FIFO.
module key_event_ctrl #(
    parameter int N_KEYS     = 4,
    parameter int LONG_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key_press,
    input  logic [N_KEYS-1:0] key_release,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_key,
    output logic [1:0]        evt_type,
    output logic              ovf
);

    localparam int KW = 2;
    localparam int CW = $clog2(LONG_CNT);
    localparam logic [CW-1:0] LONG_MAX   = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] REPEAT_MAX = CW'(REPEAT_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_LONG   = 2'd1;
    localparam logic [1:0] EVT_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } key_st_e;

    key_st_e           st_r      [N_KEYS];
    key_st_e           st_nxt_s  [N_KEYS];
    logic [CW-1:0]     cnt_r     [N_KEYS];
    logic [CW-1:0]     cnt_nxt_s [N_KEYS];
    logic [N_KEYS-1:0] emit_s;
    logic [1:0]        emit_type_s [N_KEYS];

    logic [N_KEYS-1:0] pend_valid_r;
    logic [1:0]        pend_type_r [N_KEYS];
    logic [N_KEYS-1:0] drop_s;

    logic [KW-1:0]     rr_ptr_r;
    logic [N_KEYS-1:0] grant_s;
    logic              grant_valid_s;
    logic [KW-1:0]     grant_idx_s;
    logic [2:0]        cand_s;

    logic [3:0]        fifo_mem_r [4];
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [2:0]        fifo_cnt_r;
    logic [2:0]        fifo_cnt_nxt_s;
    logic [2:0]        remain_s;
    logic [1:0]        rd_ptr_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic [3:0]        push_data_s;
    logic [3:0]        head_r;
    logic [3:0]        head_nxt_s;
    logic              evt_valid_r;
    logic              ovf_r;

    // Per-key hold-timer FSM next state, counter and event emission
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            st_nxt_s[i]    = st_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            emit_s[i]      = 1'b0;
            emit_type_s[i] = EVT_SHORT;
            case (st_r[i])
                S_IDLE: begin
                    if (key_press[i] && !key_release[i]) begin
                        st_nxt_s[i]  = S_HELD;
                        cnt_nxt_s[i] = '0;
                    end else begin
                        cnt_nxt_s[i] = '0;
                    end
                end
                S_HELD: begin
                    // a release on the LONG boundary still counts as a short press
                    if (key_release[i]) begin
                        st_nxt_s[i]    = S_IDLE;
                        cnt_nxt_s[i]   = '0;
                        emit_s[i]      = 1'b1;
                        emit_type_s[i] = EVT_SHORT;
                    end else if (cnt_r[i] == LONG_MAX) begin
                        st_nxt_s[i]    = S_LONG;
                        cnt_nxt_s[i]   = '0;
                        emit_s[i]      = 1'b1;
                        emit_type_s[i] = EVT_LONG;
                    end else begin
                        cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
                    end
                end
                S_LONG: begin
                    if (key_release[i]) begin
                        st_nxt_s[i]    = S_IDLE;
                        cnt_nxt_s[i]   = '0;
                    end else if (cnt_r[i] == REPEAT_MAX) begin
                        cnt_nxt_s[i]   = '0;
                        emit_s[i]      = 1'b1;
                        emit_type_s[i] = EVT_REPEAT;
                    end else begin
                        cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    st_nxt_s[i]  = S_IDLE;
                    cnt_nxt_s[i] = '0;
                end
            endcase
        end
    end

    // Per-key FSM state and counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                st_r[i]  <= S_IDLE;
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                st_r[i]  <= st_nxt_s[i];
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Round-robin search over pending slots, gated by the registered FIFO count
    always_comb begin
        grant_s       = '0;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = 3'd0;
        if (fifo_cnt_r < 3'd4) begin
            for (int off = 0; off < N_KEYS; off++) begin
                cand_s = {1'b0, rr_ptr_r} + 3'(off);
                if (cand_s >= 3'(N_KEYS)) begin
                    cand_s = cand_s - 3'(N_KEYS);
                end else begin
                    cand_s = cand_s;
                end
                if (!grant_valid_s && pend_valid_r[cand_s[KW-1:0]]) begin
                    grant_valid_s                = 1'b1;
                    grant_idx_s                  = cand_s[KW-1:0];
                    grant_s[cand_s[KW-1:0]]      = 1'b1;
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Drop detection: new event into an occupied slot that is not leaving
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            drop_s[i] = emit_s[i] & pend_valid_r[i] & ~grant_s[i];
        end
    end

    // Pending slots, round-robin pointer and sticky overflow flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_valid_r <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                pend_type_r[i] <= EVT_SHORT;
            end
            rr_ptr_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (emit_s[i] && (!pend_valid_r[i] || grant_s[i])) begin
                    pend_valid_r[i] <= 1'b1;
                    pend_type_r[i]  <= emit_type_s[i];
                end else if (grant_s[i]) begin
                    pend_valid_r[i] <= 1'b0;
                end else begin
                    pend_valid_r[i] <= pend_valid_r[i];
                end
            end
            if (grant_valid_s) begin
                rr_ptr_r <= (grant_idx_s == KW'(N_KEYS - 1)) ? '0 : grant_idx_s + KW'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            ovf_r <= ovf_r | (|drop_s);
        end
    end

    // FIFO control and next head entry presented to the consumer
    always_comb begin
        push_s         = grant_valid_s;
        pop_s          = evt_valid_r & evt_ready;
        push_data_s    = {grant_idx_s, pend_type_r[grant_idx_s]};
        fifo_cnt_nxt_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, pop_s};
        rd_ptr_nxt_s   = rd_ptr_r + {1'b0, pop_s};
        remain_s       = fifo_cnt_r - {2'b00, pop_s};
        // an entry still queued becomes head; else a push into the empty FIFO does
        if (remain_s != 3'd0) begin
            head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // FIFO storage, pointers, count and registered head outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < 4; j++) begin
                fifo_mem_r[j] <= 4'd0;
            end
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            fifo_cnt_r  <= 3'd0;
            head_r      <= 4'd0;
            evt_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            head_r      <= head_nxt_s;
            evt_valid_r <= (fifo_cnt_nxt_s != 3'd0);
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_key   = head_r[3:2];
    assign evt_type  = head_r[1:0];
    assign ovf       = ovf_r;

endmodule
